sram_rr_arbiter: RTL and testbench

Round-robin arbiter and access sequencer for the shared board SRAM in the MIPS system. Shares the memory among up to N_PORTS requesters (I-fetch, D-access, DMA, debug). Per-port wait states are runtime-programmable through a small config port. Drives grant, read/write direction, memory select and a one-cycle ready pulse per access.

---
 rtl/sram_rr_arbiter_pkg.sv | 17 +
 rtl/sram_rr_arbiter_if.sv | 28 ++
 rtl/sram_rr_arbiter_rr_pick.sv | 29 ++
 rtl/sram_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_rr_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rr_arbiter_pkg.sv
// Shared constants and state encoding for the SRAM round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sram_arb_pkg;

    localparam int N_PORTS = 4;
    localparam int PORT_W  = 2;
    localparam int WS_W    = 4;
    localparam logic [WS_W-1:0] DEF_WAIT = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sram_rr_arbiter_if.sv
// Requester/config side bundle of the SRAM arbiter.
// Latency: n/a (wires only).
// Backpressure: requests are levels held until the ready pulse.
interface sram_rr_arbiter_if import sram_arb_pkg::*;;

    logic [N_PORTS-1:0] read_request;
    logic [N_PORTS-1:0] write_request;
    logic               skip_wait;
    logic               cfg_we;
    logic [PORT_W-1:0]  cfg_port;
    logic [WS_W-1:0]    cfg_wait;
    logic [N_PORTS-1:0] grant;
    logic [PORT_W-1:0]  grant_id;
    logic               rwbar;
    logic               mem_sel;
    logic               ready;

    modport master (
        output read_request, write_request, skip_wait, cfg_we, cfg_port, cfg_wait,
        input  grant, grant_id, rwbar, mem_sel, ready
    );

    modport slave (
        input  read_request, write_request, skip_wait, cfg_we, cfg_port, cfg_wait,
        output grant, grant_id, rwbar, mem_sel, ready
    );

endinterface

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, with wrap.
// Latency: combinational.
// Backpressure: none; any=0 when nothing is requested.
module rr_pick import sram_arb_pkg::*; (
    input  logic [N_PORTS-1:0] req,
    input  logic [PORT_W-1:0]  ptr,
    output logic [N_PORTS-1:0] onehot,
    output logic [PORT_W-1:0]  idx,
    output logic               any
);

    logic [PORT_W-1:0] cand;

    // Walk offsets from furthest to nearest so the nearest requester wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        cand   = '0;
        any    = |req;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            cand = ptr + PORT_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
        onehot[idx] = any;
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter and access sequencer for the shared board SRAM.
// Latency: grant 1 cycle after request, ready at wait+2, next grant at wait+4 earliest.
// Backpressure: requesters hold their level request until the one-cycle ready pulse.
module sram_rr_arbiter import sram_arb_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    sram_rr_arbiter_if.slave  bus
);

    state_t             state, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [PORT_W-1:0]  grant_id_q, grant_id_d;
    logic               rwbar_q, rwbar_d;
    logic               mem_sel_q, mem_sel_d;
    logic               ready_q, ready_d;
    logic [WS_W-1:0]    wait_cnt, wait_cnt_d;
    logic [PORT_W-1:0]  rr_ptr, rr_ptr_d;
    logic [WS_W-1:0]    wait_cfg [N_PORTS];

    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] pick_onehot;
    logic [PORT_W-1:0]  pick_idx;
    logic               pick_any;

    assign req = bus.read_request | bus.write_request;

    rr_pick u_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d    = state;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rwbar_d    = rwbar_q;
        mem_sel_d  = mem_sel_q;
        ready_d    = ready_q;
        wait_cnt_d = wait_cnt;
        rr_ptr_d   = rr_ptr;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_onehot;
                    grant_id_d = pick_idx;
                    // A port raising both lines is treated as a write.
                    rwbar_d    = ~bus.write_request[pick_idx] & bus.read_request[pick_idx];
                    mem_sel_d  = 1'b1;
                    wait_cnt_d = wait_cfg[pick_idx];
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt == '0 || bus.skip_wait) begin
                    ready_d   = 1'b1;
                    mem_sel_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt - WS_W'(1);
                end
            end
            ST_DONE: begin
                ready_d    = 1'b0;
                grant_d    = '0;
                grant_id_d = '0;
                rwbar_d    = 1'b0;
                rr_ptr_d   = grant_id_q + PORT_W'(1);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register; reset aborts any access without a ready pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rwbar_q    <= 1'b0;
            mem_sel_q  <= 1'b0;
            ready_q    <= 1'b0;
            wait_cnt   <= '0;
            rr_ptr     <= '0;
        end else begin
            state      <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rwbar_q    <= rwbar_d;
            mem_sel_q  <= mem_sel_d;
            ready_q    <= ready_d;
            wait_cnt   <= wait_cnt_d;
            rr_ptr     <= rr_ptr_d;
        end
    end

    // Per-port wait-state registers; writes land on the next edge in any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_PORTS; i++) begin
                wait_cfg[i] <= DEF_WAIT;
            end
        end else if (bus.cfg_we) begin
            wait_cfg[bus.cfg_port] <= bus.cfg_wait;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.rwbar    = rwbar_q;
    assign bus.mem_sel  = mem_sel_q;
    assign bus.ready    = ready_q;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter against a transaction-level model.
// Latency: n/a.
// Backpressure: requests held until ready, as a well-behaved requester would.
module tb_sram_rr_arbiter;
    import sram_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    sram_rr_arbiter_if bus ();

    sram_rr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Transaction-level model: rotation pointer and programmed wait values.
    int mptr;
    int mcfg [4];

    // Observations of one access, counted in cycles after the request is applied.
    int         g_cyc, r_cyc, r_cnt, d_cyc;
    logic [3:0] g_val, r_grant;
    logic [1:0] id_val;
    logic       rw_val, ms_val;

    function automatic int model_winner(input logic [3:0] rq, input int ptr);
        for (int off = 0; off < 4; off++) begin
            if (rq[(ptr + off) % 4]) return (ptr + off) % 4;
        end
        return -1;
    endfunction

    function automatic int model_ready_cyc(input int w, input int skip_at);
        if (skip_at > 0 && skip_at < w + 1) return skip_at + 1;
        return w + 2;
    endfunction

    task automatic model_reset();
        mptr = 0;
        for (int i = 0; i < 4; i++) mcfg[i] = int'(DEF_WAIT);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int port, input int val);
        bus.cfg_we   = 1'b1;
        bus.cfg_port = port[1:0];
        bus.cfg_wait = val[3:0];
        step();
        bus.cfg_we   = 1'b0;
        mcfg[port]   = val;
    endtask

    // Records one access; next requests are applied at cycle chg_at, or at ready if chg_at<=0.
    task automatic measure(input logic [3:0] nrd, input logic [3:0] nwr,
                           input int chg_at, input int skip_at);
        g_cyc = -1; r_cyc = -1; r_cnt = 0; d_cyc = -1;
        g_val = '0; r_grant = '0; id_val = '0; rw_val = 1'b0; ms_val = 1'b0;
        for (int k = 1; k <= 60 && d_cyc < 0; k++) begin
            step();
            bus.skip_wait = (k == skip_at);
            if (bus.grant != 4'd0 && g_cyc < 0) begin
                g_cyc = k; g_val = bus.grant; id_val = bus.grant_id;
                rw_val = bus.rwbar; ms_val = bus.mem_sel;
            end
            if (bus.ready) begin
                r_cnt++;
                if (r_cyc < 0) begin r_cyc = k; r_grant = bus.grant; end
            end
            if (g_cyc >= 0 && bus.grant == 4'd0) d_cyc = k;
            if ((chg_at > 0 && k == chg_at) || (chg_at <= 0 && bus.ready)) begin
                bus.read_request  = nrd;
                bus.write_request = nwr;
            end
        end
        bus.skip_wait = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (bus.grant !== 4'd0)    begin bad++; $display("FAIL reset_grant got=%b want=0000", bus.grant); end
        total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", bus.grant_id); end
        total++; if (bus.rwbar !== 1'b0)    begin bad++; $display("FAIL reset_rwbar got=%b want=0", bus.rwbar); end
        total++; if (bus.mem_sel !== 1'b0)  begin bad++; $display("FAIL reset_mem_sel got=%b want=0", bus.mem_sel); end
        total++; if (bus.ready !== 1'b0)    begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ready); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single_read();
        int w, rc;
        bus.read_request = 4'b0010;
        w  = model_winner(4'b0010, mptr);
        rc = model_ready_cyc(mcfg[w], 0);
        measure(4'b0000, 4'b0000, 0, 0);
        total++; if (g_cyc !== 1)             begin bad++; $display("FAIL single_grant_cyc got=%0d want=1", g_cyc); end
        total++; if (g_val !== 4'(1 << w))    begin bad++; $display("FAIL single_grant got=%b want=%b", g_val, 4'(1 << w)); end
        total++; if (int'(id_val) !== w)      begin bad++; $display("FAIL single_grant_id got=%0d want=%0d", id_val, w); end
        total++; if (rw_val !== 1'b1)         begin bad++; $display("FAIL single_rwbar got=%b want=1", rw_val); end
        total++; if (ms_val !== 1'b1)         begin bad++; $display("FAIL single_mem_sel got=%b want=1", ms_val); end
        total++; if (r_cyc !== rc)            begin bad++; $display("FAIL single_ready_cyc got=%0d want=%0d", r_cyc, rc); end
        total++; if (r_cnt !== 1)             begin bad++; $display("FAIL single_ready_cnt got=%0d want=1", r_cnt); end
        total++; if (r_grant !== 4'(1 << w))  begin bad++; $display("FAIL single_grant_at_ready got=%b want=%b", r_grant, 4'(1 << w)); end
        total++; if (d_cyc !== rc + 1)        begin bad++; $display("FAIL single_drop_cyc got=%0d want=%0d", d_cyc, rc + 1); end
        mptr = (w + 1) % 4;
    endtask

    task automatic test_round_robin();
        int w;
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        bus.read_request = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            w = model_winner(4'b1111, mptr);
            measure((i == 4) ? 4'b0000 : 4'b1111, 4'b0000, 0, 0);
            total++; if (int'(id_val) !== w || g_val !== 4'(1 << w)) begin bad++; $display("FAIL rr_order[%0d] got=%0d/%b want=%0d", i, id_val, g_val, w); end
            total++; if (g_cyc !== 1 || r_cyc !== 4 || d_cyc !== 5)  begin bad++; $display("FAIL rr_timing[%0d] got=%0d/%0d/%0d want=1/4/5", i, g_cyc, r_cyc, d_cyc); end
            total++; if (r_cnt !== 1)                                begin bad++; $display("FAIL rr_ready_cnt[%0d] got=%0d want=1", i, r_cnt); end
            mptr = (w + 1) % 4;
        end
    endtask

    task automatic test_cfg_wait();
        int rc;
        cfg_write(2, 0);
        bus.write_request = 4'b0100;
        rc = model_ready_cyc(mcfg[2], 0);
        measure(4'b0000, 4'b0000, 0, 0);
        total++; if (int'(id_val) !== 2) begin bad++; $display("FAIL cfg0_grant_id got=%0d want=2", id_val); end
        total++; if (rw_val !== 1'b0)    begin bad++; $display("FAIL cfg0_rwbar got=%b want=0", rw_val); end
        total++; if (r_cyc !== rc)       begin bad++; $display("FAIL cfg0_ready_cyc got=%0d want=%0d", r_cyc, rc); end
        mptr = 3;
        cfg_write(2, 15);
        bus.write_request = 4'b0100;
        rc = model_ready_cyc(mcfg[2], 0);
        measure(4'b0000, 4'b0000, 0, 0);
        total++; if (r_cyc !== rc)       begin bad++; $display("FAIL cfgF_ready_cyc got=%0d want=%0d", r_cyc, rc); end
        total++; if (r_cnt !== 1 || d_cyc !== rc + 1) begin bad++; $display("FAIL cfgF_end got=%0d/%0d want=1/%0d", r_cnt, d_cyc, rc + 1); end
        mptr = 3;
    endtask

    task automatic test_dir_skip();
        int rc;
        bus.read_request  = 4'b1000;
        bus.write_request = 4'b1000;
        measure(4'b0000, 4'b0000, 0, 0);
        total++; if (int'(id_val) !== 3 || rw_val !== 1'b0) begin bad++; $display("FAIL both_dir got=%0d/%b want=3/0", id_val, rw_val); end
        mptr = 0;
        bus.read_request = 4'b0001;
        rc = model_ready_cyc(mcfg[0], 1);
        measure(4'b0000, 4'b0000, 0, 1);
        total++; if (rw_val !== 1'b1)      begin bad++; $display("FAIL skip_rwbar got=%b want=1", rw_val); end
        total++; if (r_cyc !== rc)         begin bad++; $display("FAIL skip_ready_cyc got=%0d want=%0d", r_cyc, rc); end
        total++; if (d_cyc !== rc + 1)     begin bad++; $display("FAIL skip_drop_cyc got=%0d want=%0d", d_cyc, rc + 1); end
        mptr = 1;
    endtask

    task automatic test_reset_mid_access();
        int w, rc, seen;
        bus.read_request = 4'b0100;
        step();
        step();
        total++; if (bus.mem_sel !== 1'b1) begin bad++; $display("FAIL rma_in_access got=%b want=1", bus.mem_sel); end
        rst = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_port = 2'd1; bus.cfg_wait = 4'd7;
        step();
        rst = 1'b0;
        bus.cfg_we = 1'b0;
        bus.read_request = 4'b0000;
        model_reset();
        total++; if (bus.grant !== 4'd0 || bus.grant_id !== 2'd0) begin bad++; $display("FAIL rma_grant got=%b/%0d want=0000/0", bus.grant, bus.grant_id); end
        total++; if (bus.rwbar !== 1'b0 || bus.mem_sel !== 1'b0)  begin bad++; $display("FAIL rma_rw_sel got=%b/%b want=0/0", bus.rwbar, bus.mem_sel); end
        seen = int'(bus.ready);
        for (int k = 0; k < 4; k++) begin
            step();
            seen += int'(bus.ready);
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rma_no_ready got=%0d want=0", seen); end
        bus.read_request = 4'b1010;
        w  = model_winner(4'b1010, mptr);
        rc = model_ready_cyc(mcfg[w], 0);
        measure(4'b0000, 4'b0000, 0, 0);
        total++; if (int'(id_val) !== w) begin bad++; $display("FAIL rma_ptr_winner got=%0d want=%0d", id_val, w); end
        total++; if (r_cyc !== rc)       begin bad++; $display("FAIL rma_cfg_kept got=%0d want=%0d", r_cyc, rc); end
        mptr = (w + 1) % 4;
    endtask

    task automatic test_withdraw();
        int w;
        bus.read_request = 4'b0010;
        w = model_winner(4'b0010, mptr);
        measure(4'b0100, 4'b0000, 2, 0);
        total++; if (int'(id_val) !== w) begin bad++; $display("FAIL wd_first_id got=%0d want=%0d", id_val, w); end
        total++; if (r_cyc !== 4 || r_cnt !== 1) begin bad++; $display("FAIL wd_ready got=%0d/%0d want=4/1", r_cyc, r_cnt); end
        mptr = (w + 1) % 4;
        w = model_winner(4'b0100, mptr);
        measure(4'b0000, 4'b0000, 0, 0);
        total++; if (g_cyc !== 1 || int'(id_val) !== w) begin bad++; $display("FAIL wd_next_grant got=%0d/%0d want=1/%0d", g_cyc, id_val, w); end
        mptr = (w + 1) % 4;
    endtask

    task automatic test_random();
        logic [3:0] rd, wr;
        int w, rc, sk;
        logic exp_rw;
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
            rd = 4'($urandom_range(0, 15));
            wr = 4'($urandom_range(0, 15));
            if ((rd | wr) == 4'd0) rd = 4'b0100;
            w      = model_winner(rd | wr, mptr);
            exp_rw = rd[w] & ~wr[w];
            sk     = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, mcfg[w] + 2)) : 0;
            rc     = model_ready_cyc(mcfg[w], sk);
            bus.read_request  = rd;
            bus.write_request = wr;
            measure(4'b0000, 4'b0000, 0, sk);
            total++; if (g_cyc !== 1 || g_val !== 4'(1 << w) || int'(id_val) !== w) begin bad++; $display("FAIL rnd_grant[%0d] got=%0d/%b/%0d want=1/%b/%0d", n, g_cyc, g_val, id_val, 4'(1 << w), w); end
            total++; if (rw_val !== exp_rw) begin bad++; $display("FAIL rnd_rwbar[%0d] got=%b want=%b", n, rw_val, exp_rw); end
            total++; if (r_cyc !== rc || r_cnt !== 1 || d_cyc !== rc + 1) begin bad++; $display("FAIL rnd_timing[%0d] got=%0d/%0d/%0d want=%0d/1/%0d", n, r_cyc, r_cnt, d_cyc, rc, rc + 1); end
            mptr = (w + 1) % 4;
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.read_request  = '0;
        bus.write_request = '0;
        bus.skip_wait     = 1'b0;
        bus.cfg_we        = 1'b0;
        bus.cfg_port      = '0;
        bus.cfg_wait      = '0;
        model_reset();
        test_reset();
        test_single_read();
        test_round_robin();
        test_cfg_wait();
        test_dir_skip();
        test_reset_mid_access();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
